// File: rtl/mem_string_scanner_pkg.sv
// -----------------------------------------------------------------------------
// mem_scan_pkg
//
// Shared definitions for the memory string scanner:
//   - default geometry (word width, address width, memory depth, pattern size)
//   - scanner FSM state encoding
//   - pattern byte-select helper used by the window comparator
//
// No ports; imported by the interface, the top module and the window/compare
// sub-module.
// -----------------------------------------------------------------------------
package mem_scan_pkg;

    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LENGTH  = 8;
    localparam int DEFAULT_ADDR_W  = 6;
    localparam int DEFAULT_PAT_MAX = 8;

    // Scanner FSM states. The top module keeps its state register as plain
    // logic and uses localparam aliases of these values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Window slot 0 holds the newest byte, so for a pattern of length len the
    // byte expected in slot `slot` is pattern byte (len - 1 - slot).
    // Only meaningful for slot < len.
    function automatic int unsigned pat_sel(input int unsigned slot,
                                            input int unsigned len);
        return len - 1 - slot;
    endfunction

endpackage

// File: rtl/mem_string_scanner_if.sv
// -----------------------------------------------------------------------------
// mem_string_scanner_if
//
// Bundles the scanner's request/result handshake with its memory read port.
//
// Signals:
//   start       request pulse from the controller
//   text_len    number of valid text bytes (0..DEPTH)
//   pattern     packed pattern bytes, byte 0 in the low LENGTH bits
//   pat_len     pattern length in characters
//   read_addr   address driven to the memory read port
//   dataout     memory read data, one cycle after read_addr
//   busy        search in progress
//   done        one-cycle end-of-search pulse
//   found       match result, held until the next accepted start
//   match_addr  address of the first character of the first match
//
// Modports:
//   master  controller / memory side (drives request and read data)
//   slave   scanner side
// -----------------------------------------------------------------------------
interface mem_string_scanner_if import mem_scan_pkg::*; #(
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int PAT_MAX = DEFAULT_PAT_MAX
);

    logic                        start;
    logic [ADDR_W:0]             text_len;
    logic [PAT_MAX*LENGTH-1:0]   pattern;
    logic [3:0]                  pat_len;
    logic [ADDR_W-1:0]           read_addr;
    logic [LENGTH-1:0]           dataout;
    logic                        busy;
    logic                        done;
    logic                        found;
    logic [ADDR_W-1:0]           match_addr;

    modport master (
        output start, text_len, pattern, pat_len, dataout,
        input  read_addr, busy, done, found, match_addr
    );

    modport slave (
        input  start, text_len, pattern, pat_len, dataout,
        output read_addr, busy, done, found, match_addr
    );

endinterface

// File: rtl/mem_string_scanner_scan_window_cmp.sv
// -----------------------------------------------------------------------------
// scan_window_cmp
//
// Sliding byte window plus a parallel comparator masked by the pattern length.
// Every shift pushes a new byte into slot 0 and ages the others by one slot;
// the comparator checks the pat_len newest slots against the pattern in
// reverse order, so a match is seen as soon as its last byte arrives.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   clear        empty the window and restart byte counting
//   shift_en     data_in is valid this cycle; shift it in
//   data_in      byte read from memory
//   pattern      latched pattern bytes, byte 0 in the low LENGTH bits
//   pat_len      latched pattern length
//   hit          window currently ends with the full pattern
//   newest_addr  text address of the byte in slot 0
//   rx_count     number of bytes shifted in since the last clear
// -----------------------------------------------------------------------------
module scan_window_cmp import mem_scan_pkg::*; #(
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int PAT_MAX = DEFAULT_PAT_MAX
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic [LENGTH-1:0]         data_in,
    input  logic [PAT_MAX*LENGTH-1:0] pattern,
    input  logic [3:0]                pat_len,
    output logic                      hit,
    output logic [ADDR_W-1:0]         newest_addr,
    output logic [ADDR_W:0]           rx_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SEL_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

    logic [LENGTH-1:0] win_q [PAT_MAX];
    logic [LENGTH-1:0] win_d [PAT_MAX];
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [ADDR_W-1:0] newest_addr_q, newest_addr_d;

    logic              all_eq;
    logic [SEL_W-1:0]  sel;

    // The byte being shifted in has address equal to the number of bytes
    // already received, because reads are issued strictly from address 0.
    always_comb begin
        win_d         = win_q;
        rx_count_d    = rx_count_q;
        newest_addr_d = newest_addr_q;
        if (clear) begin
            for (int i = 0; i < PAT_MAX; i++) begin
                win_d[i] = '0;
            end
            rx_count_d    = '0;
            newest_addr_d = '0;
        end else if (shift_en) begin
            win_d[0] = data_in;
            for (int i = 1; i < PAT_MAX; i++) begin
                win_d[i] = win_q[i-1];
            end
            newest_addr_d = rx_count_q[ADDR_W-1:0];
            rx_count_d    = rx_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAT_MAX; i++) begin
                win_q[i] <= '0;
            end
            rx_count_q    <= '0;
            newest_addr_q <= '0;
        end else begin
            for (int i = 0; i < PAT_MAX; i++) begin
                win_q[i] <= win_d[i];
            end
            rx_count_q    <= rx_count_d;
            newest_addr_q <= newest_addr_d;
        end
    end

    // Slots at or beyond pat_len are masked out. Requiring at least pat_len
    // received bytes keeps stale or cleared slots from producing a match.
    always_comb begin
        all_eq = 1'b1;
        sel    = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(pat_len)) begin
                sel = SEL_W'(pat_sel(unsigned'(i), 32'(pat_len)));
                if (win_q[i] != pattern[int'(sel)*LENGTH +: LENGTH]) begin
                    all_eq = 1'b0;
                end
            end
        end
        hit = all_eq && (rx_count_q >= CNT_W'(pat_len));
    end

    assign newest_addr = newest_addr_q;
    assign rx_count    = rx_count_q;

endmodule

// File: rtl/mem_string_scanner.sv
// -----------------------------------------------------------------------------
// mem_string_scanner
//
// Read-side master for a memory with a registered read port (data appears one
// cycle after the address). On an accepted start it reads addresses
// 0..text_len-1 in order, streams the bytes through a sliding compare window
// and stops at the first occurrence of the pattern.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; aborts a scan without a done pulse
//   bus   slave side of mem_string_scanner_if (request, result and memory
//         read port signals)
// -----------------------------------------------------------------------------
module mem_string_scanner import mem_scan_pkg::*; #(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int PAT_MAX = DEFAULT_PAT_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_string_scanner_if.slave  bus
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]                state_q, state_d;
    logic [ADDR_W-1:0]         read_addr_q, read_addr_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]          text_len_q, text_len_d;
    logic [3:0]                pat_len_q, pat_len_d;
    logic [PAT_MAX*LENGTH-1:0] pattern_q, pattern_d;
    logic                      found_q, found_d;
    logic [ADDR_W-1:0]         match_addr_q, match_addr_d;

    logic                      win_clear;
    logic                      win_hit;
    logic [ADDR_W-1:0]         newest_addr;
    logic [CNT_W-1:0]          rx_count;

    logic                      req_bad;
    logic                      last_addr;
    logic                      drained;
    logic [ADDR_W-1:0]         hit_addr;

    scan_window_cmp #(
        .LENGTH  (LENGTH),
        .ADDR_W  (ADDR_W),
        .PAT_MAX (PAT_MAX)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .clear       (win_clear),
        .shift_en    (rd_valid_q),
        .data_in     (bus.dataout),
        .pattern     (pattern_q),
        .pat_len     (pat_len_q),
        .hit         (win_hit),
        .newest_addr (newest_addr),
        .rx_count    (rx_count)
    );

    // Requests that can never match finish immediately without touching
    // memory. The address comparison is done one bit wider than read_addr so
    // a full-depth scan ends at DEPTH-1 instead of wrapping.
    always_comb begin
        req_bad   = (bus.pat_len == 4'd0)
                 || (int'(bus.pat_len) > PAT_MAX)
                 || (CNT_W'(bus.pat_len) > bus.text_len)
                 || (int'(bus.text_len) > DEPTH);
        last_addr = ({1'b0, read_addr_q} == (text_len_q - CNT_W'(1)));
        drained   = (rx_count == text_len_q);
        hit_addr  = newest_addr - ADDR_W'(pat_len_q) + ADDR_W'(1);
    end

    // Main FSM. rd_valid marks the cycle in which dataout carries the byte
    // for the address issued one cycle earlier; it is dropped on a hit so
    // outstanding reads are discarded.
    always_comb begin
        state_d      = state_q;
        read_addr_d  = read_addr_q;
        rd_valid_d   = 1'b0;
        text_len_d   = text_len_q;
        pat_len_d    = pat_len_q;
        pattern_d    = pattern_q;
        found_d      = found_q;
        match_addr_d = match_addr_q;
        win_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    text_len_d   = bus.text_len;
                    pat_len_d    = bus.pat_len;
                    pattern_d    = bus.pattern;
                    found_d      = 1'b0;
                    match_addr_d = '0;
                    read_addr_d  = '0;
                    win_clear    = 1'b1;
                    state_d      = req_bad ? ST_DONE : ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (win_hit) begin
                    state_d      = ST_DONE;
                    found_d      = 1'b1;
                    match_addr_d = hit_addr;
                end else begin
                    rd_valid_d = 1'b1;
                    if (last_addr) begin
                        state_d = ST_DRAIN;
                    end else begin
                        read_addr_d = read_addr_q + ADDR_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (win_hit) begin
                    state_d      = ST_DONE;
                    found_d      = 1'b1;
                    match_addr_d = hit_addr;
                end else if (drained) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            read_addr_q  <= '0;
            rd_valid_q   <= 1'b0;
            text_len_q   <= '0;
            pat_len_q    <= '0;
            pattern_q    <= '0;
            found_q      <= 1'b0;
            match_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            read_addr_q  <= read_addr_d;
            rd_valid_q   <= rd_valid_d;
            text_len_q   <= text_len_d;
            pat_len_q    <= pat_len_d;
            pattern_q    <= pattern_d;
            found_q      <= found_d;
            match_addr_q <= match_addr_d;
        end
    end

    assign bus.read_addr  = read_addr_q;
    assign bus.busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.found      = found_q;
    assign bus.match_addr = match_addr_q;

endmodule

// File: tb/tb_mem_string_scanner.sv
// -----------------------------------------------------------------------------
// tb_mem_string_scanner
//
// Directed bench for mem_string_scanner. A registered-read memory model sits
// on the interface; each step launches a search and checks the done timing
// (edges after the start edge), found and match_addr against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_mem_string_scanner;
    import mem_scan_pkg::*;

    localparam int DEPTH   = 64;
    localparam int LENGTH  = 8;
    localparam int ADDR_W  = 6;
    localparam int PAT_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int e0       = 0;

    logic [LENGTH-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    mem_string_scanner_if #(
        .LENGTH  (LENGTH),
        .ADDR_W  (ADDR_W),
        .PAT_MAX (PAT_MAX)
    ) bus ();

    mem_string_scanner #(
        .DEPTH   (DEPTH),
        .LENGTH  (LENGTH),
        .ADDR_W  (ADDR_W),
        .PAT_MAX (PAT_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory with one cycle of read latency.
    always @(posedge clk) begin
        bus.dataout <= mem[bus.read_addr];
    end

    // Edge counter used to time done relative to the start edge.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents a request at the negedge, lets the next rising edge (E0)
    // sample it, then withdraws start.
    task automatic applyStimulus(input logic [63:0] pat, input logic [3:0] plen,
                                 input logic [6:0] tlen);
        @(negedge clk);
        bus.pattern  = pat;
        bus.pat_len  = plen;
        bus.text_len = tlen;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        e0        = edge_cnt;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int exp_edge,
                            input logic exp_found, input logic [5:0] exp_addr);
        int guard;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput({tag, " done seen"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " done edge"}, edge_cnt - e0, exp_edge);
        checkOutput({tag, " found"}, 32'(bus.found), 32'(exp_found));
        checkOutput({tag, " match_addr"}, 32'(bus.match_addr), 32'(exp_addr));
        checkOutput({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic endCycle(input string tag, input logic exp_found,
                            input logic [5:0] exp_addr);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse width"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " found held"}, 32'(bus.found), 32'(exp_found));
        checkOutput({tag, " addr held"}, 32'(bus.match_addr), 32'(exp_addr));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.pat_len  = '0;
        bus.text_len = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        mem[0] = 8'd2;  mem[1] = 8'd3;  mem[2] = 8'd4;
        mem[3] = 8'd8;  mem[4] = 8'd23; mem[5] = 8'd10;
        mem[6] = 8'd11; mem[7] = 8'd12; mem[8] = 8'd24;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset found", 32'(bus.found), 32'd0);
        checkOutput("reset match_addr", 32'(bus.match_addr), 32'd0);
        checkOutput("reset read_addr", 32'(bus.read_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pattern 8,23,10 ends at address 5
        applyStimulus(64'({8'd10, 8'd23, 8'd8}), 4'd3, 7'd9);
        checkOutput("t1 busy", 32'(bus.busy), 32'd1);
        waitDone("t1", 8, 1'b1, 6'd3);
        endCycle("t1", 1'b1, 6'd3);

        // Pattern 12,24 ends on the last address
        applyStimulus(64'({8'd24, 8'd12}), 4'd2, 7'd9);
        waitDone("t2", 11, 1'b1, 6'd7);
        endCycle("t2", 1'b1, 6'd7);

        // Pattern 24,2 only exists across a wrap: not found
        applyStimulus(64'({8'd2, 8'd24}), 4'd2, 7'd9);
        waitDone("t3 nowrap", 11, 1'b0, 6'd0);
        checkOutput("t3 read_addr hold", 32'(bus.read_addr), 32'd8);
        endCycle("t3 nowrap", 1'b0, 6'd0);

        // pat_len equal to text_len
        applyStimulus(64'({8'd4, 8'd3, 8'd2}), 4'd3, 7'd3);
        waitDone("t4 full", 5, 1'b1, 6'd0);
        endCycle("t4 full", 1'b1, 6'd0);

        // Invalid: pat_len 0 (clears the previous found)
        applyStimulus(64'({8'd2}), 4'd0, 7'd9);
        checkOutput("inv0 read_addr", 32'(bus.read_addr), 32'd0);
        waitDone("inv0", 0, 1'b0, 6'd0);
        endCycle("inv0", 1'b0, 6'd0);

        // Invalid: pat_len longer than text
        applyStimulus(64'({8'd8, 8'd4, 8'd3, 8'd2}), 4'd4, 7'd3);
        checkOutput("inv4 read_addr", 32'(bus.read_addr), 32'd0);
        waitDone("inv4", 0, 1'b0, 6'd0);
        endCycle("inv4", 1'b0, 6'd0);

        // Start pulsed while busy must be ignored
        applyStimulus(64'({8'd10, 8'd23, 8'd8}), 4'd3, 7'd9);
        @(negedge clk);
        bus.pattern = 64'({8'd24, 8'd12});
        bus.pat_len = 4'd2;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy-start busy", 32'(bus.busy), 32'd1);
        waitDone("busy-start", 8, 1'b1, 6'd3);

        // Start held during the DONE cycle must be ignored as well
        bus.start = 1'b1;
        endCycle("done-start", 1'b1, 6'd3);
        bus.start = 1'b0;
        endCycle("done-start idle", 1'b1, 6'd3);

        // Asynchronous reset in the middle of a scan
        applyStimulus(64'({8'd10, 8'd23, 8'd8}), 4'd3, 7'd9);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre-rst read_addr", 32'(bus.read_addr), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst busy", 32'(bus.busy), 32'd0);
        checkOutput("rst done", 32'(bus.done), 32'd0);
        checkOutput("rst found", 32'(bus.found), 32'd0);
        checkOutput("rst read_addr", 32'(bus.read_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst no done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Restart after reset
        applyStimulus(64'({8'd24, 8'd12}), 4'd2, 7'd9);
        waitDone("restart", 11, 1'b1, 6'd7);
        endCycle("restart", 1'b1, 6'd7);

        // Overlapping repeated characters
        mem[0] = 8'd3; mem[1] = 8'd3; mem[2] = 8'd3;
        applyStimulus(64'({8'd3, 8'd3}), 4'd2, 7'd3);
        waitDone("repeat", 4, 1'b1, 6'd0);
        endCycle("repeat", 1'b1, 6'd0);

        // Full-depth text: match at the very end, then a wrap-only pattern
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        applyStimulus(64'({8'd63, 8'd62}), 4'd2, 7'd64);
        waitDone("depth", 66, 1'b1, 6'd62);
        endCycle("depth", 1'b1, 6'd62);

        applyStimulus(64'({8'd0, 8'd63}), 4'd2, 7'd64);
        waitDone("depth nowrap", 66, 1'b0, 6'd0);
        checkOutput("depth read_addr hold", 32'(bus.read_addr), 32'd63);
        endCycle("depth nowrap", 1'b0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
